sp_ram_ctrl: RTL

SP_RAM_CTRL -- requirements
Module: sp_ram_ctrl

---
 rtl/sp_ram_pkg.sv | 25 ++
 rtl/sp_ram_rd_pipe.sv | 89 ++++++++
 rtl/sp_ram_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sp_ram_pkg.sv
// ---------------------------------------------------------------------------
// sp_ram_pkg
// Shared types and constants for the single-port RAM controller:
//   state_e          - controller FSM states (sweep-initialise / ready)
//   DEF_*            - default values for the controller parameters
//   byte_parity()    - even-parity bit for one byte (XOR of its bits, so the
//                      byte plus its parity bit always holds an even number
//                      of ones)
// ---------------------------------------------------------------------------
package sp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_READ_LATENCY = 1;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// sp_ram_rd_pipe
// Read-return pipeline. Its inputs come from the RAM output register, which
// is already one cycle after the read was accepted; this block adds the
// remaining READ_LATENCY-1 stages (none for READ_LATENCY=1).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (flushes stages)
//   in_valid        stage-1 valid (read accepted on the previous edge)
//   in_data         stage-1 read word (holds between reads)
//   in_err          stage-1 parity mismatch flag
//   rvalid          one-cycle pulse, READ_LATENCY cycles after accept
//   rdata           read word, holds the last returned value
//   parity_err      mismatch flag, only ever high together with rvalid
// ---------------------------------------------------------------------------
module sp_ram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  parity_err
);

  if (READ_LATENCY <= 1) begin : g_direct
    // The RAM output register has no reset, so rdata is masked to zero
    // until the first read since reset has come back.
    logic seen_q, seen_d;

    assign seen_d = seen_q | in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_q <= 1'b0;
      else        seen_q <= seen_d;
    end

    assign rvalid     = in_valid;
    assign rdata      = seen_d ? in_data : '0;
    assign parity_err = in_valid & in_err;
  end else begin : g_stages
    localparam int N = READ_LATENCY - 1;

    logic                  vld_q [N];
    logic                  vld_d [N];
    logic [DATA_WIDTH-1:0] dat_q [N];
    logic [DATA_WIDTH-1:0] dat_d [N];
    logic                  err_q [N];
    logic                  err_d [N];

    // Data/err stages load only when a valid word moves into them, so the
    // last stage naturally holds the previous read value.
    always_comb begin
      vld_d[0] = in_valid;
      dat_d[0] = in_valid ? in_data : dat_q[0];
      err_d[0] = in_valid ? in_err  : err_q[0];
      for (int i = 1; i < N; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        err_d[i] = vld_q[i-1] ? err_q[i-1] : err_q[i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          vld_q[i] <= 1'b0;
          dat_q[i] <= '0;
          err_q[i] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          vld_q[i] <= vld_d[i];
          dat_q[i] <= dat_d[i];
          err_q[i] <= err_d[i];
        end
      end
    end

    assign rvalid     = vld_q[N-1];
    assign rdata      = dat_q[N-1];
    assign parity_err = vld_q[N-1] & err_q[N-1];
  end

endmodule

// File: rtl/sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl
// Single-port RAM controller with a self-initialising zero sweep, per-byte
// write enables and a pipelined read path of READ_LATENCY (1..3) cycles.
// After reset or a clr request the whole array is written with zero, one
// word per cycle, before accesses are accepted again.
//
// Optional feature macro: RAM_PARITY_EN
//   defined   - one even-parity bit is stored per byte; a read whose stored
//               parity disagrees with its data raises parity_err with rvalid
//   undefined - no parity storage, parity_err is constant 0
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          access request (only sampled while ready=1)
//   we          1 = write, 0 = read
//   be          per-byte write enable (BE_WIDTH = DATA_WIDTH/8)
//   addr        word address (naturally modulo DEPTH)
//   wdata       write data
//   clr         request to re-zero the array (wins over a same-cycle access)
//   ready       1 while accesses are accepted
//   rdata       registered read data, holds when rvalid=0
//   rvalid      one-cycle pulse qualifying rdata
//   parity_err  read parity mismatch, aligned with rvalid
// ---------------------------------------------------------------------------
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    clr,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    parity_err
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  rd_vld_q, rd_vld_d;

  logic                  accept;
  logic                  rd_accept;
  logic [BE_WIDTH-1:0]   ram_be;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [BE_WIDTH-1:0]   lane_err;
  logic                  rd_err;

  assign ready     = (state_q == ST_READY);
  // clr takes priority: an access presented alongside it is dropped.
  assign accept    = ready & en & ~clr;
  assign rd_accept = accept & ~we;
  assign rd_vld_d  = rd_accept;

  // -------------------------------------------------------------------------
  // FSM: INIT sweeps every address once, READY serves accesses.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        // clr is deliberately not looked at here: the running sweep
        // already produces the all-zero array it asks for.
        if (sweep_q == '1) begin
          state_d = ST_READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_INIT;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // -------------------------------------------------------------------------
  // Write port mux: the sweep owns the port in INIT, accepted writes in READY.
  // -------------------------------------------------------------------------
  always_comb begin
    ram_be    = '0;
    ram_waddr = addr;
    ram_wdata = wdata;
    if (state_q == ST_INIT) begin
      ram_be    = '1;
      ram_waddr = sweep_q;
      ram_wdata = '0;
    end else if (accept && we) begin
      ram_be    = be;
    end
  end

  // -------------------------------------------------------------------------
  // Storage, one array per byte lane so each lane has a plain write enable.
  // The output register loads only on an accepted read and carries no
  // reset, keeping the array + register shape a block RAM maps onto.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (ram_be[gi]) lane_mem[ram_waddr] <= ram_wdata[8*gi +: 8];
      if (rd_accept)  lane_rd_q <= lane_mem[addr];
    end

    assign rd_word[8*gi +: 8] = lane_rd_q;

`ifdef RAM_PARITY_EN
    logic lane_par [DEPTH];
    logic lane_par_rd_q;

    always_ff @(posedge clk) begin
      if (ram_be[gi]) lane_par[ram_waddr] <= byte_parity(ram_wdata[8*gi +: 8]);
      if (rd_accept)  lane_par_rd_q <= lane_par[addr];
    end

    assign lane_err[gi] = byte_parity(lane_rd_q) ^ lane_par_rd_q;
`else
    assign lane_err[gi] = 1'b0;
`endif
  end

  assign rd_err = |lane_err;

  sp_ram_rd_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (rd_vld_q),
    .in_data    (rd_word),
    .in_err     (rd_err),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .parity_err (parity_err)
  );

endmodule
